// File: rtl/md5_step_sequencer_if.sv
// Purpose: bundles the block/digest handshakes and the round-unit bus of the MD5 step sequencer.
// Latency: none; this file holds only wires.
// Backpressure: in_ready/out_ready are carried here and are decoded by the sequencer.
interface md5_step_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block;
    logic [127:0] cv_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] digest;
    logic         busy;
    logic [31:0]  rnd_a;
    logic [31:0]  rnd_b;
    logic [31:0]  rnd_c;
    logic [31:0]  rnd_d;
    logic [31:0]  rnd_message;
    logic [31:0]  rnd_s;
    logic [31:0]  rnd_t;
    logic [1:0]   rnd_sel;
    logic [31:0]  rnd_a_next;

    // Sequencer side
    modport slave (
        input  in_valid, block, cv_in, out_ready, rnd_a_next,
        output in_ready, out_valid, digest, busy,
               rnd_a, rnd_b, rnd_c, rnd_d, rnd_message, rnd_s, rnd_t, rnd_sel
    );

    // Environment side: block source, digest sink and round unit
    modport master (
        output in_valid, block, cv_in, out_ready, rnd_a_next,
        input  in_ready, out_valid, digest, busy,
               rnd_a, rnd_b, rnd_c, rnd_d, rnd_message, rnd_s, rnd_t, rnd_sel
    );
endinterface

// File: rtl/md5_step_sequencer.sv
// Purpose: steps one 512-bit block through 64 MD5 steps via an external combinational round unit, then adds the chaining value.
// Latency: 65 cycles accept-to-out_valid, 66 cycles minimum accept-to-accept; one step per cycle.
// Backpressure: digest held while out_ready is low; in_ready stays low until the digest is taken. Option MD5_DIGEST_BSWAP_EN byte-reverses each output word.
module md5_step_sequencer #(
    parameter int NSTEPS = 64
) (
    input  logic clk,
    input  logic rst,
    md5_step_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] LAST_STEP = 6'(NSTEPS - 1);

    state_t       state, state_nxt;
    logic [5:0]   step;
    logic [31:0]  a, b, c, d;
    logic [127:0] cv_q;
    logic [127:0] digest_q;
    logic [31:0]  m_reg [16];
    logic [3:0]   g;
    logic [4:0]   s5;
    logic [31:0]  t_rom;
    logic         running;

    assign running = (state == RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)       state_nxt = RUN;
            RUN:     if (step == LAST_STEP)  state_nxt = DONE;
            DONE:    if (bus.out_ready)      state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Message index per round; the multiplies only matter modulo 16
    always_comb begin
        g = step[3:0];
        case (step[5:4])
            2'd0:    g = step[3:0];
            2'd1:    g = step[3:0] * 4'd5 + 4'd1;
            2'd2:    g = step[3:0] * 4'd3 + 4'd5;
            default: g = step[3:0] * 4'd7;
        endcase
    end

    // Rotate amount, cycling through four values per round
    always_comb begin
        s5 = 5'd0;
        case ({step[5:4], step[1:0]})
            4'h0: s5 = 5'd7;   4'h1: s5 = 5'd12;  4'h2: s5 = 5'd17;  4'h3: s5 = 5'd22;
            4'h4: s5 = 5'd5;   4'h5: s5 = 5'd9;   4'h6: s5 = 5'd14;  4'h7: s5 = 5'd20;
            4'h8: s5 = 5'd4;   4'h9: s5 = 5'd11;  4'ha: s5 = 5'd16;  4'hb: s5 = 5'd23;
            4'hc: s5 = 5'd6;   4'hd: s5 = 5'd10;  4'he: s5 = 5'd15;  default: s5 = 5'd21;
        endcase
    end

    // Additive constant ROM, T[i] = floor(|sin(i+1)| * 2^32)
    always_comb begin
        t_rom = 32'd0;
        case (step)
            6'd0:  t_rom = 32'hd76aa478;  6'd1:  t_rom = 32'he8c7b756;  6'd2:  t_rom = 32'h242070db;  6'd3:  t_rom = 32'hc1bdceee;
            6'd4:  t_rom = 32'hf57c0faf;  6'd5:  t_rom = 32'h4787c62a;  6'd6:  t_rom = 32'ha8304613;  6'd7:  t_rom = 32'hfd469501;
            6'd8:  t_rom = 32'h698098d8;  6'd9:  t_rom = 32'h8b44f7af;  6'd10: t_rom = 32'hffff5bb1;  6'd11: t_rom = 32'h895cd7be;
            6'd12: t_rom = 32'h6b901122;  6'd13: t_rom = 32'hfd987193;  6'd14: t_rom = 32'ha679438e;  6'd15: t_rom = 32'h49b40821;
            6'd16: t_rom = 32'hf61e2562;  6'd17: t_rom = 32'hc040b340;  6'd18: t_rom = 32'h265e5a51;  6'd19: t_rom = 32'he9b6c7aa;
            6'd20: t_rom = 32'hd62f105d;  6'd21: t_rom = 32'h02441453;  6'd22: t_rom = 32'hd8a1e681;  6'd23: t_rom = 32'he7d3fbc8;
            6'd24: t_rom = 32'h21e1cde6;  6'd25: t_rom = 32'hc33707d6;  6'd26: t_rom = 32'hf4d50d87;  6'd27: t_rom = 32'h455a14ed;
            6'd28: t_rom = 32'ha9e3e905;  6'd29: t_rom = 32'hfcefa3f8;  6'd30: t_rom = 32'h676f02d9;  6'd31: t_rom = 32'h8d2a4c8a;
            6'd32: t_rom = 32'hfffa3942;  6'd33: t_rom = 32'h8771f681;  6'd34: t_rom = 32'h6d9d6122;  6'd35: t_rom = 32'hfde5380c;
            6'd36: t_rom = 32'ha4beea44;  6'd37: t_rom = 32'h4bdecfa9;  6'd38: t_rom = 32'hf6bb4b60;  6'd39: t_rom = 32'hbebfbc70;
            6'd40: t_rom = 32'h289b7ec6;  6'd41: t_rom = 32'heaa127fa;  6'd42: t_rom = 32'hd4ef3085;  6'd43: t_rom = 32'h04881d05;
            6'd44: t_rom = 32'hd9d4d039;  6'd45: t_rom = 32'he6db99e5;  6'd46: t_rom = 32'h1fa27cf8;  6'd47: t_rom = 32'hc4ac5665;
            6'd48: t_rom = 32'hf4292244;  6'd49: t_rom = 32'h432aff97;  6'd50: t_rom = 32'hab9423a7;  6'd51: t_rom = 32'hfc93a039;
            6'd52: t_rom = 32'h655b59c3;  6'd53: t_rom = 32'h8f0ccc92;  6'd54: t_rom = 32'hffeff47d;  6'd55: t_rom = 32'h85845dd1;
            6'd56: t_rom = 32'h6fa87e4f;  6'd57: t_rom = 32'hfe2ce6e0;  6'd58: t_rom = 32'ha3014314;  6'd59: t_rom = 32'h4e0811a1;
            6'd60: t_rom = 32'hf7537e82;  6'd61: t_rom = 32'hbd3af235;  6'd62: t_rom = 32'h2ad7d2bb;  default: t_rom = 32'heb86d391;
        endcase
    end

    // Block/CV capture, working-register rotation and the final chaining add.
    // The digest add uses the post-step values of step 63: A=D, B=a_next, C=B, D=C.
    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            c        <= '0;
            d        <= '0;
            step     <= '0;
            cv_q     <= '0;
            digest_q <= '0;
            for (int k = 0; k < 16; k++) m_reg[k] <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    for (int k = 0; k < 16; k++) m_reg[k] <= bus.block[32*k +: 32];
                    cv_q <= bus.cv_in;
                    a    <= bus.cv_in[31:0];
                    b    <= bus.cv_in[63:32];
                    c    <= bus.cv_in[95:64];
                    d    <= bus.cv_in[127:96];
                    step <= '0;
                end
                RUN: begin
                    a    <= d;
                    d    <= c;
                    c    <= b;
                    b    <= bus.rnd_a_next;
                    step <= step + 6'd1;
                    if (step == LAST_STEP)
                        digest_q <= {cv_q[127:96] + c, cv_q[95:64] + b,
                                     cv_q[63:32] + bus.rnd_a_next, cv_q[31:0] + d};
                end
                default: ;
            endcase
        end
    end

    // Round-unit bus: step-dependent fields are zero outside RUN so reset drives all zeros
    assign bus.rnd_a       = a;
    assign bus.rnd_b       = b;
    assign bus.rnd_c       = c;
    assign bus.rnd_d       = d;
    assign bus.rnd_sel     = running ? step[5:4] : 2'd0;
    assign bus.rnd_message = running ? m_reg[g] : 32'd0;
    assign bus.rnd_s       = running ? {27'd0, s5} : 32'd0;
    assign bus.rnd_t       = running ? t_rom : 32'd0;

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = running;
    assign bus.out_valid = (state == DONE);

`ifdef MD5_DIGEST_BSWAP_EN
    // Canonical hex order: byte-reverse every word of the little-endian packing
    always_comb begin
        bus.digest = '0;
        for (int w = 0; w < 4; w++)
            for (int y = 0; y < 4; y++)
                bus.digest[32*w + 8*y +: 8] = digest_q[32*w + 8*(3-y) +: 8];
    end
`else
    assign bus.digest = digest_q;
`endif
endmodule
